udp_payload_checker: RTL and testbench

- Receive-side consumer for the 16-bit payload stream produced by network_stack_rx (axiov/axiod).
- Checks each received frame against the fixed 7-word test pattern that the transmit-side button generator injects into network_stack_tx.
- Keeps good/bad frame counters and a latched first-mismatch record for bring-up on the board.
- Sits on the eth_refclk (50 MHz) domain beside network_stack_rx.

---
 rtl/udp_test_pkg.sv | 27 ++
 rtl/sat_counter.sv | 19 +
 rtl/udp_payload_checker.sv | 143 ++++++++++++++
 tb/tb_udp_payload_checker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_test_pkg.sv
// Shared definitions for the UDP payload test path: the fixed test pattern
// injected on transmit and the receive-side checker state encoding.
package udp_test_pkg;

  localparam int TEST_PATTERN_LEN = 7;

  localparam logic [0:TEST_PATTERN_LEN-1][15:0] TEST_PATTERN = {
    16'hABCD, 16'h6969, 16'hFFFF, 16'h0420, 16'hABCD, 16'h6969, 16'hFFFF
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } checker_state_t;

  // Out-of-range indices return 0; callers treat those words as errors anyway.
  function automatic logic [15:0] pattern_word(input logic [3:0] idx);
    logic [15:0] word;
    word = '0;
    for (int i = 0; i < TEST_PATTERN_LEN; i++) begin
      if (idx == i[3:0]) word = TEST_PATTERN[i];
    end
    return word;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/udp_payload_checker.sv
// Checks received payload frames against the fixed UDP test pattern.
// Define PAYLOAD_CHECKER_PASSTHRU_EN to add a registered axiov/axiod copy of the input.
module udp_payload_checker
  import udp_test_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int PATTERN_LEN = TEST_PATTERN_LEN,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axiiv,
  input  logic [DATA_SIZE-1:0] axiid,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [CNT_W-1:0]     good_count,
  output logic [CNT_W-1:0]     bad_count,
  output logic [3:0]           bad_index,
  output logic [DATA_SIZE-1:0] bad_data,
  output logic                 busy
`ifdef PAYLOAD_CHECKER_PASSTHRU_EN
  ,
  output logic                 axiov,
  output logic [DATA_SIZE-1:0] axiod
`endif
);

  localparam logic [3:0] PLEN = 4'(PATTERN_LEN);

  checker_state_t state, state_next;
  logic [3:0]           index, index_next;
  logic                 err_flag, err_flag_next;
  logic [3:0]           err_index, err_index_next;
  logic [DATA_SIZE-1:0] err_data, err_data_next;

  logic [3:0] cur_idx;
  logic       word_err;
  logic       frame_end;
  logic       frame_good;

  // Word 0 of a new frame can arrive in IDLE or REPORT, where index still holds the old length.
  assign cur_idx    = (state == CHECK) ? index : 4'd0;
  assign word_err   = (cur_idx >= PLEN) || (axiid != pattern_word(cur_idx));
  assign frame_end  = (state == CHECK) && !axiiv;
  assign frame_good = !err_flag && (index == PLEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      index     <= '0;
      err_flag  <= 1'b0;
      err_index <= '0;
      err_data  <= '0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      err_flag  <= err_flag_next;
      err_index <= err_index_next;
      err_data  <= err_data_next;
    end
  end

  always_comb begin
    state_next     = state;
    index_next     = index;
    err_flag_next  = err_flag;
    err_index_next = err_index;
    err_data_next  = err_data;
    case (state)
      IDLE, REPORT: begin
        state_next = IDLE;
        if (axiiv) begin
          state_next     = CHECK;
          index_next     = 4'd1;
          err_flag_next  = word_err;
          err_index_next = 4'd0;
          err_data_next  = axiid;
        end
      end
      CHECK: begin
        if (axiiv) begin
          if (!err_flag && word_err) begin
            err_flag_next  = 1'b1;
            err_index_next = index;
            err_data_next  = axiid;
          end
          if (index != 4'hF) index_next = index + 4'd1;
        end else begin
          state_next = REPORT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Verdict registers load as REPORT is entered so they line up with the frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      bad_index  <= '0;
      bad_data   <= '0;
      busy       <= 1'b0;
    end else begin
      frame_done <= frame_end;
      busy       <= (state_next == CHECK);
      if (frame_end) begin
        frame_ok <= frame_good;
        if (!frame_good) begin
          bad_index <= err_flag ? err_index : index;
          bad_data  <= err_flag ? err_data : '0;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_good_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_end && frame_good),
    .count (good_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bad_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_end && !frame_good),
    .count (bad_count)
  );

`ifdef PAYLOAD_CHECKER_PASSTHRU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      axiov <= axiiv;
      axiod <= axiid;
    end
  end
`endif

endmodule

// File: tb/tb_udp_payload_checker.sv
// Directed self-checking bench for udp_payload_checker, built with narrow 4-bit counters.
// Follows PAYLOAD_CHECKER_PASSTHRU_EN to connect the optional pass-through ports.
module tb_udp_payload_checker;

  localparam int DATA_SIZE = 16;
  localparam int CNT_W     = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 axiiv;
  logic [DATA_SIZE-1:0] axiid;
  logic                 frame_done;
  logic                 frame_ok;
  logic [CNT_W-1:0]     good_count;
  logic [CNT_W-1:0]     bad_count;
  logic [3:0]           bad_index;
  logic [DATA_SIZE-1:0] bad_data;
  logic                 busy;
`ifdef PAYLOAD_CHECKER_PASSTHRU_EN
  logic                 axiov;
  logic [DATA_SIZE-1:0] axiod;
`endif

  int checks;
  int failures;

  logic [15:0] good_pat [7];
  logic [15:0] frame_buf [16];

  udp_payload_checker #(
    .DATA_SIZE   (DATA_SIZE),
    .PATTERN_LEN (7),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .good_count (good_count),
    .bad_count  (bad_count),
    .bad_index  (bad_index),
    .bad_data   (bad_data),
    .busy       (busy)
`ifdef PAYLOAD_CHECKER_PASSTHRU_EN
    ,
    .axiov      (axiov),
    .axiod      (axiod)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_good();
    for (int i = 0; i < 16; i++) frame_buf[i] = 16'h0000;
    for (int i = 0; i < 7; i++) frame_buf[i] = good_pat[i];
  endtask

  task automatic drive_words(input int n);
    for (int i = 0; i < n; i++) begin
      axiiv = 1'b1;
      axiid = frame_buf[i];
      step();
    end
  endtask

  // Drops valid for one cycle; returns positioned in the frame_done cycle.
  task automatic send_buf(input int n);
    drive_words(n);
    axiiv = 1'b0;
    axiid = 16'h0000;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = 16'h0000;
    step();
    step();
    checks++;
    if ({frame_done, frame_ok, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=000", {frame_done, frame_ok, busy});
    end
    checks++;
    if ({good_count, bad_count, bad_index, bad_data} !== 28'h0) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h want=0", {good_count, bad_count, bad_index, bad_data});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_frame();
    load_good();
    drive_words(7);
    axiiv = 1'b0;
    axiid = 16'h0000;
`ifdef PAYLOAD_CHECKER_PASSTHRU_EN
    checks++;
    if ({axiov, axiod} !== {1'b1, 16'hFFFF}) begin
      failures++;
      $display("[TB] FAIL passthru got=%b/%h want=1/ffff", axiov, axiod);
    end
`endif
    checks++;
    if ({frame_done, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL good_before_done got=%b want=01", {frame_done, busy});
    end
    step();
    checks++;
    if ({frame_done, frame_ok, busy} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL good_done_flags got=%b want=110", {frame_done, frame_ok, busy});
    end
    checks++;
    if (good_count !== 4'd1 || bad_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL good_counts got=%0d/%0d want=1/0", good_count, bad_count);
    end
    step();
    checks++;
    if ({frame_done, frame_ok} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL good_after_pulse got=%b want=01", {frame_done, frame_ok});
    end
  endtask

  task automatic test_corrupt_word();
    load_good();
    frame_buf[3] = 16'h0421;
    send_buf(7);
    checks++;
    if ({frame_done, frame_ok} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL corrupt_flags got=%b want=10", {frame_done, frame_ok});
    end
    checks++;
    if ({bad_index, bad_data} !== {4'd3, 16'h0421}) begin
      failures++;
      $display("[TB] FAIL corrupt_record got=%0d/%h want=3/0421", bad_index, bad_data);
    end
    checks++;
    if (good_count !== 4'd1 || bad_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL corrupt_counts got=%0d/%0d want=1/1", good_count, bad_count);
    end
    step();
  endtask

  task automatic test_short_long();
    load_good();
    send_buf(5);
    checks++;
    if ({frame_done, frame_ok, bad_index, bad_data} !== {2'b10, 4'd5, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL short_frame got=%b%b/%0d/%h want=10/5/0000", frame_done, frame_ok, bad_index, bad_data);
    end
    checks++;
    if (bad_count !== 4'd2) begin
      failures++;
      $display("[TB] FAIL short_count got=%0d want=2", bad_count);
    end
    step();
    load_good();
    frame_buf[7] = 16'h1234;
    send_buf(8);
    checks++;
    if ({frame_done, frame_ok, bad_index, bad_data} !== {2'b10, 4'd7, 16'h1234}) begin
      failures++;
      $display("[TB] FAIL long_frame got=%b%b/%0d/%h want=10/7/1234", frame_done, frame_ok, bad_index, bad_data);
    end
    checks++;
    if (good_count !== 4'd1 || bad_count !== 4'd3) begin
      failures++;
      $display("[TB] FAIL long_counts got=%0d/%0d want=1/3", good_count, bad_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    load_good();
    send_buf(7);
    checks++;
    if ({frame_done, frame_ok, good_count} !== {2'b11, 4'd2}) begin
      failures++;
      $display("[TB] FAIL b2b_first got=%b%b/%0d want=11/2", frame_done, frame_ok, good_count);
    end
    send_buf(7);
    checks++;
    if ({frame_done, frame_ok, good_count} !== {2'b11, 4'd3}) begin
      failures++;
      $display("[TB] FAIL b2b_second got=%b%b/%0d want=11/3", frame_done, frame_ok, good_count);
    end
    checks++;
    if ({bad_count, bad_index, bad_data} !== {4'd3, 4'd7, 16'h1234}) begin
      failures++;
      $display("[TB] FAIL b2b_bad_kept got=%0d/%0d/%h want=3/7/1234", bad_count, bad_index, bad_data);
    end
    step();
  endtask

  task automatic test_mid_frame_reset();
    load_good();
    drive_words(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_done, frame_ok, busy, good_count, bad_count, bad_index, bad_data} !== 31'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%h want=0",
               {frame_done, frame_ok, busy, good_count, bad_count, bad_index, bad_data});
    end
    axiiv = 1'b0;
    axiid = 16'h0000;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midreset_no_done got=%b want=00", {frame_done, busy});
    end
    send_buf(7);
    checks++;
    if ({frame_done, frame_ok, good_count, bad_count} !== {2'b11, 4'd1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_next got=%b%b/%0d/%0d want=11/1/0", frame_done, frame_ok, good_count, bad_count);
    end
    step();
  endtask

  task automatic test_saturation();
    load_good();
    for (int f = 0; f < 14; f++) begin
      send_buf(7);
      step();
    end
    checks++;
    if (good_count !== 4'hF) begin
      failures++;
      $display("[TB] FAIL sat_reach got=%h want=f", good_count);
    end
    for (int f = 0; f < 2; f++) begin
      send_buf(7);
      step();
    end
    checks++;
    if ({good_count, bad_count, frame_ok} !== {4'hF, 4'h0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sat_hold got=%h/%h/%b want=f/0/1", good_count, bad_count, frame_ok);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    good_pat = '{16'hABCD, 16'h6969, 16'hFFFF, 16'h0420, 16'hABCD, 16'h6969, 16'hFFFF};
    rst_n    = 1'b0;
    axiiv    = 1'b0;
    axiid    = 16'h0000;
    test_reset();
    test_good_frame();
    test_corrupt_word();
    test_short_long();
    test_back_to_back();
    test_mid_frame_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
